fm_hop_scheduler: RTL
=====================

Name: fm_hop_scheduler

Overview:
- Wishbone master that sequences the FM generator's register slave as a frequency-hopping scheduler.
- Holds a small hop table of carrier phase increments and steps through it with a programmable dwell time.
- Each table entry is written to the carrier-centre-frequency register (address 0) over pipelined Wishbone.
- Sits between the host/config logic and the FM generator slave bus; sole master on that bus while running.

Parameters:
- TBL_AW, 4, hop table address width (table depth 2**TBL_AW).
- DWELL_W, 24, dwell counter width in clock cycles.
- ACK_TIMEOUT, 15, max cycles waiting for i_wb_ack before error.
- CARRIER_ADDR, 0, slave register index for carrier-centre increment.
- DEV_ADDR, 2, slave register index for deviation (optional feature only).

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_start  in  1  pulse; begin hopping from entry 0 (ignored unless IDLE or ERR)
- i_stop  in  1  pulse; finish any in-flight bus cycle, then return to IDLE
- i_loop  in  1  1: wrap to entry 0 after last hop; 0: stop after last hop
- i_num_hops  in  TBL_AW  index of last entry used (entries 0..i_num_hops)
- i_dwell  in  DWELL_W  dwell cycles per hop; 0 treated as 1
- i_tbl_we  in  1  table write strobe
- i_tbl_addr  in  TBL_AW  table write address
- i_tbl_data  in  32  table write data (carrier increment)
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_addr  out  2  register index
- o_wb_data  out  32  write data
- i_wb_ack  in  1  slave ack
- i_wb_stall  in  1  slave stall
- o_busy  out  1  high in any state but IDLE/ERR
- o_hop_idx  out  TBL_AW  index of the entry most recently acked
- o_hop_stb  out  1  one-cycle pulse per acked hop write
- o_err  out  1  sticky ack-timeout flag; cleared by i_start

Behaviour:
- Reset (async, i_reset_n low): state IDLE; all outputs 0; counters 0. Table contents are not reset.
- Table: synchronous-write, registered-read RAM; one cycle read latency.
- Host writes during an active run take effect on that entry's next read.
- States and transitions:
  - IDLE: i_start -> FETCH with idx=0, o_err cleared.
  - FETCH: table read issued; next cycle -> REQ with o_wb_data latched.
  - REQ: cyc=stb=we=1, addr=CARRIER_ADDR; stb held until a cycle with !i_wb_stall, then -> ACK (stb drops, cyc held).
  - ACK: timeout counter runs. i_wb_ack -> cyc=0, o_hop_stb pulse, o_hop_idx=idx -> DWELL with count=max(i_dwell,1). Counter reaching ACK_TIMEOUT without ack -> ERR.
  - DWELL: decrement each cycle; at 1: if stop pending -> IDLE; else if idx==i_num_hops: i_loop ? (idx=0, FETCH) : IDLE; else idx+1, FETCH.
  - ERR: cyc/stb low, o_err=1; i_start -> FETCH.
- Timing: acked hop to next stb assertion is exactly dwell+1 cycles (1 FETCH cycle).
- An ack arriving in the same cycle as stb acceptance (zero-wait slave) is not legal for this slave and is ignored in REQ.
- i_stop: latched as pending. In IDLE it has no effect. In FETCH/DWELL -> IDLE next cycle. In REQ/ACK the bus cycle completes (ack or timeout) first.
- i_start and i_stop in the same cycle: stop wins.
- i_num_hops, i_dwell, i_loop are sampled at each use; no shadowing.
- idx wraps only via i_loop; idx never exceeds i_num_hops.

Optional Feature:
- Macro FM_HOP_DEVIATION_EN.
- Defined:
  - Second table of 14-bit deviations, written with the same i_tbl_we/i_tbl_addr using i_tbl_data[45:32]; i_tbl_data widens to 46 bits.
  - After the carrier write acks, a second write (REQ2/ACK2 states) to DEV_ADDR with zero-extended deviation, same stall/timeout rules.
  - o_hop_stb pulses after the second ack.
- Undefined: only the carrier write; i_tbl_data is 32 bits.

Decomposition:
- Package fm_hop_pkg: state encoding constants, CARRIER_ADDR/DEV_ADDR defaults, Wishbone address width (2).
- Sub-module fm_hop_table: parameterised dual-port (1 write, 1 registered read) RAM, instantiated once, or twice with FM_HOP_DEVIATION_EN.

Test Plan:
- Reset mid-run: assert i_reset_n low during REQ -> all outputs 0 the same cycle; after release state IDLE, o_busy=0.
- Basic run: table {100,200,300}, i_num_hops=2, i_dwell=5, i_loop=0, slave acks 1 cycle after accept -> three writes addr 0 with data 100,200,300; stb-to-stb spacing 8 cycles; then IDLE; o_hop_stb pulsed 3 times.
- Stall: i_wb_stall high 4 cycles on first request -> stb held 5 cycles, data stable; single write observed.
- Loop and stop: i_loop=1, i_num_hops=1 -> sequence 0,1,0,1; i_stop in DWELL -> IDLE next cycle with no further stb; i_stop in ACK -> cycle completes, then IDLE.
- Timeout: slave never acks -> after 15 cycles in ACK, cyc drops, o_err=1, o_busy=0; i_start clears o_err and restarts at entry 0.
- Dwell zero: i_dwell=0 -> behaves as 1; stb-to-stb spacing 4 cycles with 1-cycle ack slave.

Source files
------------

// File: rtl/fm_hop_pkg.sv
// Shared definitions for the FM hop scheduler: state encoding, table widths,
// Wishbone register-index width and default parameter values.
// Optional feature macro: FM_HOP_DEVIATION_EN (adds a deviation table and a
// second register write per hop).
package fm_hop_pkg;

    localparam int WB_AW            = 2;
    localparam int CAR_W            = 32;
    localparam int DEV_W            = 14;

`ifdef FM_HOP_DEVIATION_EN
    localparam int TBL_DW           = CAR_W + DEV_W;
`else
    localparam int TBL_DW           = CAR_W;
`endif

    localparam int DEF_TBL_AW       = 4;
    localparam int DEF_DWELL_W      = 24;
    localparam int DEF_ACK_TIMEOUT  = 15;
    localparam int DEF_CARRIER_ADDR = 0;
    localparam int DEF_DEV_ADDR     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_ACK   = 3'd3,
        ST_DWELL = 3'd4,
        ST_ERR   = 3'd5,
        ST_REQ2  = 3'd6,
        ST_ACK2  = 3'd7
    } hop_state_t;

    // A run is in progress in every state except the two resting states.
    function automatic logic is_active(input hop_state_t s);
        return !((s == ST_IDLE) || (s == ST_ERR));
    endfunction

endpackage

// File: rtl/fm_hop_table.sv
// Hop table RAM: one synchronous write port, one registered read port.
// The read register holds its value until the next read enable so it can
// drive the bus data directly for the whole bus cycle.
module fm_hop_table #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [2**AW];

    // Host write port; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, held between fetches, cleared by reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/fm_hop_scheduler.sv
// Frequency-hopping scheduler: steps through a hop table and writes each
// carrier increment to the FM generator over pipelined Wishbone, waiting a
// programmable dwell between hops.
// Optional feature macro: FM_HOP_DEVIATION_EN (second write of a 14-bit
// deviation per hop to register DEV_ADDR).
module fm_hop_scheduler
    import fm_hop_pkg::*;
#(
    parameter int TBL_AW       = DEF_TBL_AW,
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
`ifdef FM_HOP_DEVIATION_EN
    parameter int DEV_ADDR     = DEF_DEV_ADDR,
`endif
    parameter int CARRIER_ADDR = DEF_CARRIER_ADDR
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_loop,
    input  logic [TBL_AW-1:0]  i_num_hops,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_tbl_we,
    input  logic [TBL_AW-1:0]  i_tbl_addr,
    input  logic [TBL_DW-1:0]  i_tbl_data,
    output logic               o_wb_cyc,
    output logic               o_wb_stb,
    output logic               o_wb_we,
    output logic [WB_AW-1:0]   o_wb_addr,
    output logic [CAR_W-1:0]   o_wb_data,
    input  logic               i_wb_ack,
    input  logic               i_wb_stall,
    output logic               o_busy,
    output logic [TBL_AW-1:0]  o_hop_idx,
    output logic               o_hop_stb,
    output logic               o_err
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    hop_state_t         state, state_nxt;
    logic [TBL_AW-1:0]  idx, idx_nxt;
    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt, dwell_load;
    logic [TO_W-1:0]    to_cnt, to_nxt;
    logic               stop_pend, stop_pend_nxt, stop_now;
    logic               err_nxt, hop_stb_nxt;
    logic [TBL_AW-1:0]  hop_idx_nxt;
    logic               tbl_re;
    logic [CAR_W-1:0]   car_rdata;

    assign stop_now   = stop_pend | i_stop;
    assign dwell_load = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign o_wb_we    = o_wb_cyc;
    assign o_busy     = is_active(state);

    fm_hop_table #(
        .AW (TBL_AW),
        .DW (CAR_W)
    ) u_car_tbl (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (i_tbl_we),
        .i_waddr   (i_tbl_addr),
        .i_wdata   (i_tbl_data[CAR_W-1:0]),
        .i_re      (tbl_re),
        .i_raddr   (idx),
        .o_rdata   (car_rdata)
    );

`ifdef FM_HOP_DEVIATION_EN
    logic [DEV_W-1:0] dev_rdata;

    fm_hop_table #(
        .AW (TBL_AW),
        .DW (DEV_W)
    ) u_dev_tbl (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (i_tbl_we),
        .i_waddr   (i_tbl_addr),
        .i_wdata   (i_tbl_data[CAR_W+DEV_W-1:CAR_W]),
        .i_re      (tbl_re),
        .i_raddr   (idx),
        .o_rdata   (dev_rdata)
    );

    assign o_wb_data = ((state == ST_REQ2) || (state == ST_ACK2))
                     ? {{(CAR_W-DEV_W){1'b0}}, dev_rdata} : car_rdata;
`else
    assign o_wb_data = car_rdata;
`endif

    // Next-state, counter updates and bus controls for the hop sequencer.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        dwell_nxt     = dwell_cnt;
        to_nxt        = to_cnt;
        stop_pend_nxt = stop_now;
        err_nxt       = o_err;
        hop_stb_nxt   = 1'b0;
        hop_idx_nxt   = o_hop_idx;
        tbl_re        = 1'b0;
        o_wb_cyc      = 1'b0;
        o_wb_stb      = 1'b0;
        o_wb_addr     = '0;

        case (state)
            ST_IDLE, ST_ERR: begin
                stop_pend_nxt = 1'b0;
                if (i_start && !i_stop) begin
                    state_nxt = ST_FETCH;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end

            ST_FETCH: begin
                tbl_re = 1'b1;
                if (stop_now) begin
                    state_nxt     = ST_IDLE;
                    stop_pend_nxt = 1'b0;
                end else begin
                    state_nxt = ST_REQ;
                end
            end

            ST_REQ: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = 1'b1;
                o_wb_addr = WB_AW'(CARRIER_ADDR);
                if (!i_wb_stall) begin
                    state_nxt = ST_ACK;
                    to_nxt    = '0;
                end
            end

            ST_ACK: begin
                o_wb_cyc  = 1'b1;
                o_wb_addr = WB_AW'(CARRIER_ADDR);
                if (i_wb_ack) begin
`ifdef FM_HOP_DEVIATION_EN
                    state_nxt   = ST_REQ2;
`else
                    state_nxt   = ST_DWELL;
                    dwell_nxt   = dwell_load;
                    hop_stb_nxt = 1'b1;
                    hop_idx_nxt = idx;
`endif
                end else if (to_cnt == TO_LAST) begin
                    state_nxt     = ST_ERR;
                    err_nxt       = 1'b1;
                    stop_pend_nxt = 1'b0;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end

`ifdef FM_HOP_DEVIATION_EN
            ST_REQ2: begin
                o_wb_cyc  = 1'b1;
                o_wb_stb  = 1'b1;
                o_wb_addr = WB_AW'(DEV_ADDR);
                if (!i_wb_stall) begin
                    state_nxt = ST_ACK2;
                    to_nxt    = '0;
                end
            end

            ST_ACK2: begin
                o_wb_cyc  = 1'b1;
                o_wb_addr = WB_AW'(DEV_ADDR);
                if (i_wb_ack) begin
                    state_nxt   = ST_DWELL;
                    dwell_nxt   = dwell_load;
                    hop_stb_nxt = 1'b1;
                    hop_idx_nxt = idx;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt     = ST_ERR;
                    err_nxt       = 1'b1;
                    stop_pend_nxt = 1'b0;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
            end
`endif

            ST_DWELL: begin
                if (stop_now) begin
                    state_nxt     = ST_IDLE;
                    stop_pend_nxt = 1'b0;
                end else if (dwell_cnt <= DWELL_W'(1)) begin
                    if (idx >= i_num_hops) begin
                        if (i_loop) begin
                            idx_nxt   = '0;
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        idx_nxt   = idx + TBL_AW'(1);
                        state_nxt = ST_FETCH;
                    end
                end else begin
                    dwell_nxt = dwell_cnt - DWELL_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            to_cnt    <= '0;
            stop_pend <= 1'b0;
            o_err     <= 1'b0;
            o_hop_stb <= 1'b0;
            o_hop_idx <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            dwell_cnt <= dwell_nxt;
            to_cnt    <= to_nxt;
            stop_pend <= stop_pend_nxt;
            o_err     <= err_nxt;
            o_hop_stb <= hop_stb_nxt;
            o_hop_idx <= hop_idx_nxt;
        end
    end

endmodule
